down_counter_4b: RTL and testbench
==================================

DOWN_COUNTER_4B -- requirements
Module: down_counter_4b

Interface
REQ-001 Parameters: none; width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in  input  4  load value; also captured as the reload value.
REQ-005 ld  input  1  load enable.
REQ-006 cnt  input  1  decrement enable.
REQ-007 reload  input  1  auto-reload mode select, sampled each cycle.
REQ-008 count  output  4  current count, registered.
REQ-009 zero  output  1  combinational; 1 when count == 4'h0.
REQ-010 bout  output  1  combinational borrow-out for cascading; 1 when state==RUN && zero && cnt.
REQ-011 busy  output  1  registered; 1 when state==RUN.
REQ-012 done  output  1  registered, sticky expiry flag.

Function
REQ-013 The block SHALL hold internal registers: count[3:0], reload_val[3:0], state in {IDLE, RUN, EXPIRED}, done.
REQ-014 In IDLE: cnt ignored; count holds; ld moves to RUN (or EXPIRED if in==0, per REQ-016).
REQ-015 In any state, ld=1: count<=in, reload_val<=in, done<=0, next state RUN if in!=0.
REQ-016 If ld=1 and in==0, the next state SHALL be EXPIRED, with done left at 0.
REQ-017 ld has priority over cnt when both are asserted in the same cycle; no decrement occurs that cycle.
REQ-018 In RUN, with ld=0, cnt=1 and count>1: count<=count-1; state stays RUN.
REQ-019 In RUN, with ld=0, cnt=1 and count==1: count<=0; done<=1; state stays RUN (zero=1 on the next cycle).
REQ-020 In RUN, with ld=0, cnt=1, count==0 and reload=1: count<=reload_val; state stays RUN; done stays 1.
REQ-021 In RUN, with ld=0, cnt=1, count==0 and reload=0: count holds 0; state<=EXPIRED.
REQ-022 In RUN, with cnt=0 and ld=0: all registers hold.
REQ-023 In EXPIRED: cnt and reload are ignored; count holds 0; only ld leaves the state.
REQ-024 Count arithmetic SHALL be unsigned 4-bit and SHALL never wrap from 0 to 4'hF.
REQ-025 bout SHALL be asserted exactly in cycles where the RUN-state zero-crossing action (REQ-020 or REQ-021) takes effect; it is never asserted in IDLE or EXPIRED.
REQ-026 done SHALL clear only on ld or reset; reload cycles SHALL NOT clear it.
REQ-027 Latency: count, busy and done SHALL reflect ld or cnt one clock after the enabling edge; zero and bout SHALL follow count and cnt combinationally.

Reset
REQ-028 On rst=0, asynchronously: count=0, reload_val=0, state=IDLE, busy=0, done=0. These imply zero=1 and bout=0.
REQ-029 Reset asserted mid-count SHALL abort the operation immediately, with no residual done.
REQ-030 After rst is released, the block SHALL remain in IDLE until the first ld.

Verification
REQ-031 After reset, cnt=1 for 5 cycles -> count=0, busy=0, bout=0, done=0.
REQ-032 ld with in=3, then cnt=1 for 5 cycles, reload=0 -> count 3,2,1,0,0. done=1 from the cycle count reaches 0. bout=1 for one cycle. Final state EXPIRED with busy=0.
REQ-033 ld with in=2 and reload=1, then cnt=1 for 7 cycles -> count 2,1,0,2,1,0,2. bout pulses twice. done=1 stays set.
REQ-034 count=5 in RUN, ld=1 with in=9 and cnt=1 in the same cycle -> count=9, done=0, no decrement that cycle.
REQ-035 ld with in=0 -> count=0, busy=0, done=0, bout=0 while cnt=1.
REQ-036 count=4 in RUN, rst pulsed low between clock edges -> count=0, busy=0, done=0 immediately. Subsequent cnt is ignored until ld.

Source files
------------

// File: rtl/down_counter_4b.sv
// 4-bit loadable down counter with optional auto-reload and a sticky expiry flag.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-low reset
//   in     - load value, also captured as the reload value
//   ld     - load enable (wins over cnt)
//   cnt    - decrement enable, honoured only while running
//   reload - auto-reload select, sampled every cycle
//   count  - current count (registered)
//   zero   - count == 0 (combinational)
//   bout   - borrow-out for cascading, high in the cycle a zero-crossing action applies (combinational)
//   busy   - high while running (registered)
//   done   - sticky expiry flag, cleared only by ld or reset (registered)
module down_counter_4b (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in,
  input  logic         ld,
  input  logic         cnt,
  input  logic         reload,
  output logic [3:0]   count,
  output logic         zero,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   reload_val;
  logic [W-1:0]   count_nxt;
  logic [W-1:0]   reload_nxt;
  logic           done_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_val <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_val <= reload_nxt;
      done       <= done_nxt;
      busy       <= (state_nxt == RUN);
    end
  end

  // Next-state and datapath update; ld takes priority over any decrement
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_val;
    done_nxt   = done;

    if (ld) begin
      count_nxt  = in;
      reload_nxt = in;
      done_nxt   = 1'b0;
      // A zero load has nothing to count, so it expires straight away without raising done
      state_nxt  = (in != '0) ? RUN : EXPIRED;
    end else begin
      case (state)
        RUN: begin
          if (cnt) begin
            if (count > W'(1)) begin
              count_nxt = count - W'(1);
            end else if (count == W'(1)) begin
              count_nxt = '0;
              done_nxt  = 1'b1;
            end else if (reload) begin
              count_nxt = reload_val;
            end else begin
              state_nxt = EXPIRED;
            end
          end
        end
        default: begin
          // IDLE and EXPIRED ignore cnt and reload; only ld leaves them
        end
      endcase
    end
  end

  // Borrow fires only when the zero-crossing action really happens, so a
  // simultaneous ld (which pre-empts it) suppresses it
  assign zero = (count == '0);
  assign bout = (state == RUN) && zero && cnt && !ld;

endmodule

// File: tb/tb_down_counter_4b.sv
// Directed self-checking bench for down_counter_4b.
module tb_down_counter_4b;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       ld;
  logic       cnt;
  logic       reload;
  logic [3:0] count;
  logic       zero;
  logic       bout;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  down_counter_4b dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .ld     (ld),
    .cnt    (cnt),
    .reload (reload),
    .count  (count),
    .zero   (zero),
    .bout   (bout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] c32 [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
  logic       b32 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       d32 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       y32 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic [3:0] c33 [7] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1};
  logic       b33 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       d33 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  logic [3:0] c36 [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd4};
  logic       d36 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b0; in = 4'd0; ld = 1'b0; cnt = 1'b0; reload = 1'b0;
    #12;
    // Reset values
    chk("rst_count", count, 4'd0);
    chk("rst_zero",  4'(zero), 4'd1);
    chk("rst_bout",  4'(bout), 4'd0);
    chk("rst_busy",  4'(busy), 4'd0);
    chk("rst_done",  4'(done), 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // cnt in IDLE is ignored
    cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_bout", 4'(bout), 4'd0);
      tick();
    end
    chk("idle_count", count, 4'd0);
    chk("idle_busy",  4'(busy), 4'd0);
    chk("idle_done",  4'(done), 4'd0);

    // Load 3, count down without reload
    cnt = 1'b0; ld = 1'b1; in = 4'd3; reload = 1'b0;
    tick();
    chk("ld3_count", count, 4'd3);
    chk("ld3_busy",  4'(busy), 4'd1);
    ld = 1'b0; cnt = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      chk("r0_bout", 4'(bout), 4'(b32[i]));
      if (bout) pulses++;
      tick();
      chk("r0_count", count, c32[i]);
      chk("r0_done",  4'(done), 4'(d32[i]));
      chk("r0_busy",  4'(busy), 4'(y32[i]));
    end
    chk("r0_pulses", 4'(pulses), 4'd1);

    // Expired ignores cnt and reload, done stays sticky
    reload = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("exp_bout", 4'(bout), 4'd0);
      tick();
    end
    chk("exp_count", count, 4'd0);
    chk("exp_busy",  4'(busy), 4'd0);
    chk("exp_done",  4'(done), 4'd1);

    // Load 2 with auto-reload
    cnt = 1'b0; ld = 1'b1; in = 4'd2; reload = 1'b1;
    tick();
    chk("ld2_count", count, 4'd2);
    chk("ld2_done",  4'(done), 4'd0);
    ld = 1'b0; cnt = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      chk("r1_bout", 4'(bout), 4'(b33[i]));
      if (bout) pulses++;
      tick();
      chk("r1_count", count, c33[i]);
      chk("r1_done",  4'(done), 4'(d33[i]));
      chk("r1_busy",  4'(busy), 4'd1);
    end
    chk("r1_pulses", 4'(pulses), 4'd2);

    // ld beats cnt in the same cycle
    cnt = 1'b0; ld = 1'b1; in = 4'd5; reload = 1'b0;
    tick();
    chk("ld5_count", count, 4'd5);
    chk("ld5_done",  4'(done), 4'd0);
    ld = 1'b1; cnt = 1'b1; in = 4'd9;
    chk("ldcnt_bout", 4'(bout), 4'd0);
    tick();
    chk("ldcnt_count", count, 4'd9);
    chk("ldcnt_done",  4'(done), 4'd0);
    chk("ldcnt_busy",  4'(busy), 4'd1);

    // Zero load goes straight to expired without done
    ld = 1'b1; in = 4'd0; cnt = 1'b1;
    tick();
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld0_bout", 4'(bout), 4'd0);
      tick();
      chk("ld0_count", count, 4'd0);
      chk("ld0_busy",  4'(busy), 4'd0);
      chk("ld0_done",  4'(done), 4'd0);
    end

    // Load 4 with reload, run past expiry so done is set, then reset mid-cycle
    ld = 1'b1; in = 4'd4; reload = 1'b1; cnt = 1'b0;
    tick();
    chk("ld4_count", count, 4'd4);
    ld = 1'b0; cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r4_count", count, c36[i]);
      chk("r4_done",  4'(done), 4'(d36[i]));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 4'd0);
    chk("arst_busy",  4'(busy), 4'd0);
    chk("arst_done",  4'(done), 4'd0);
    chk("arst_zero",  4'(zero), 4'd1);
    chk("arst_bout",  4'(bout), 4'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_count", count, 4'd0);
      chk("post_busy",  4'(busy), 4'd0);
    end
    cnt = 1'b0; ld = 1'b1; in = 4'd3;
    tick();
    chk("post_ld_count", count, 4'd3);
    chk("post_ld_busy",  4'(busy), 4'd1);
    ld = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
